// File: rtl/sal_addr_decoder_arb.sv
// AXI AR/AW address arbiter and bank/row/column decoder feeding a single registered
// request slot toward the bank controller.
module sal_addr_decoder_arb #(
   parameter int unsigned ID_WIDTH     = 4,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter int unsigned LEN_WIDTH    = 8,
   parameter int unsigned OFFSET_WIDTH = 4,
   parameter int unsigned CA_WIDTH     = 10,
   parameter int unsigned BA_WIDTH     = 2,
   parameter int unsigned RA_WIDTH     = 16,
   parameter int unsigned MAP_MODE     = 0,
   parameter int unsigned ARB_MODE     = 0,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   input  logic [ID_WIDTH-1:0]   ar_id,
   input  logic [ADDR_WIDTH-1:0] ar_addr,
   input  logic [LEN_WIDTH-1:0]  ar_len,
   input  logic                  aw_valid,
   output logic                  aw_ready,
   input  logic [ID_WIDTH-1:0]   aw_id,
   input  logic [ADDR_WIDTH-1:0] aw_addr,
   input  logic [LEN_WIDTH-1:0]  aw_len,
   output logic                  req_valid,
   input  logic                  req_ready,
   output logic [ID_WIDTH-1:0]   req_id,
   output logic [BA_WIDTH-1:0]   req_ba,
   output logic [RA_WIDTH-1:0]   req_ra,
   output logic [CA_WIDTH-1:0]   req_ca,
   output logic [LEN_WIDTH-1:0]  req_len,
   output logic                  req_wr
);

   localparam int unsigned STREAK_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam int unsigned MAP_W    = CA_WIDTH + BA_WIDTH + RA_WIDTH;
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

   logic [STREAK_W-1:0]   streak_q;
   logic                  last_wr_q;
   logic                  load_en;
   logic                  grant_wr;
   logic                  grant_rd;
   logic                  hs;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [MAP_W-1:0]      a;
   logic [BA_WIDTH-1:0]   ba;
   logic [RA_WIDTH-1:0]   ra;
   logic [CA_WIDTH-1:0]   ca;

   always_comb begin
      grant_wr = 1'b0;
      grant_rd = 1'b0;
      if (aw_valid && !ar_valid) begin
         grant_wr = 1'b1;
      end else if (ar_valid && !aw_valid) begin
         grant_rd = 1'b1;
      end else if (ar_valid && aw_valid) begin
         if (ARB_MODE == 1) begin
            grant_wr = !last_wr_q;
            grant_rd = last_wr_q;
         end else if (STARVE_LIMIT > 0 && streak_q == STREAK_MAX) begin
            grant_rd = 1'b1;
         end else begin
            grant_wr = 1'b1;
         end
      end
   end

   assign load_en  = !req_valid || req_ready;
   // Readies are held low during reset so no request slips in while the slot is cleared.
   assign aw_ready = !rst && load_en && grant_wr;
   assign ar_ready = !rst && load_en && grant_rd;
   assign hs       = aw_ready || ar_ready;

   assign sel_addr = grant_wr ? aw_addr : ar_addr;
   // Zero-extend before shifting so address bits above the map are simply dropped.
   assign a = MAP_W'({{MAP_W{1'b0}}, sel_addr} >> OFFSET_WIDTH);

   always_comb begin
      ca = a[CA_WIDTH-1:0];
      ba = '0;
      ra = '0;
      if (MAP_MODE == 1) begin
         ra = a[CA_WIDTH +: RA_WIDTH];
         ba = a[CA_WIDTH+RA_WIDTH +: BA_WIDTH];
      end else begin
         ba = a[CA_WIDTH +: BA_WIDTH];
         ra = a[CA_WIDTH+BA_WIDTH +: RA_WIDTH];
         if (MAP_MODE == 2) begin
            ba = ba ^ ra[BA_WIDTH-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_valid <= 1'b0;
         req_id    <= '0;
         req_ba    <= '0;
         req_ra    <= '0;
         req_ca    <= '0;
         req_len   <= '0;
         req_wr    <= 1'b0;
         streak_q  <= '0;
         last_wr_q <= 1'b0;
      end else if (hs) begin
         req_valid <= 1'b1;
         req_id    <= grant_wr ? aw_id : ar_id;
         req_len   <= grant_wr ? aw_len : ar_len;
         req_ba    <= ba;
         req_ra    <= ra;
         req_ca    <= ca;
         req_wr    <= grant_wr;
         last_wr_q <= grant_wr;
         // Only writes that actually beat a waiting read count toward starvation.
         if (grant_wr && ar_valid) begin
            if (streak_q != STREAK_MAX) begin
               streak_q <= streak_q + 1'b1;
            end
         end else begin
            streak_q <= '0;
         end
      end else if (req_ready) begin
         req_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sal_addr_decoder_arb.sv
// Bench for sal_addr_decoder_arb: three instances with different map/arbitration settings
// share one stimulus stream; a scoreboard queue holds expected requests in lockstep.
module tb_sal_addr_decoder_arb;

   typedef struct packed {
      logic        wr;
      logic [3:0]  id;
      logic [1:0]  ba;
      logic [15:0] ra;
      logic [9:0]  ca;
      logic [7:0]  len;
   } item_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ar_valid = 1'b0;
   logic        aw_valid = 1'b0;
   logic        req_ready = 1'b1;
   logic [3:0]  ar_id = '0;
   logic [3:0]  aw_id = '0;
   logic [31:0] ar_addr = '0;
   logic [31:0] aw_addr = '0;
   logic [7:0]  ar_len = '0;
   logic [7:0]  aw_len = '0;

   logic [2:0]  ar_rdy, aw_rdy, vld;
   logic [3:0]  r_id  [3];
   logic [1:0]  r_ba  [3];
   logic [15:0] r_ra  [3];
   logic [9:0]  r_ca  [3];
   logic [7:0]  r_len [3];
   logic        r_wr  [3];

   int    n_pass = 0;
   int    n_chk  = 0;
   item_t exp_q[$];

   always #5 clk = ~clk;

   sal_addr_decoder_arb #(.MAP_MODE(0), .ARB_MODE(0), .STARVE_LIMIT(4)) u0 (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_rdy[0]), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
      .aw_valid(aw_valid), .aw_ready(aw_rdy[0]), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
      .req_valid(vld[0]), .req_ready(req_ready), .req_id(r_id[0]), .req_ba(r_ba[0]),
      .req_ra(r_ra[0]), .req_ca(r_ca[0]), .req_len(r_len[0]), .req_wr(r_wr[0])
   );

   sal_addr_decoder_arb #(.MAP_MODE(1), .ARB_MODE(0), .STARVE_LIMIT(0)) u1 (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_rdy[1]), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
      .aw_valid(aw_valid), .aw_ready(aw_rdy[1]), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
      .req_valid(vld[1]), .req_ready(req_ready), .req_id(r_id[1]), .req_ba(r_ba[1]),
      .req_ra(r_ra[1]), .req_ca(r_ca[1]), .req_len(r_len[1]), .req_wr(r_wr[1])
   );

   sal_addr_decoder_arb #(.MAP_MODE(2), .ARB_MODE(1), .STARVE_LIMIT(4)) u2 (
      .clk(clk), .rst(rst),
      .ar_valid(ar_valid), .ar_ready(ar_rdy[2]), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
      .aw_valid(aw_valid), .aw_ready(aw_rdy[2]), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
      .req_valid(vld[2]), .req_ready(req_ready), .req_id(r_id[2]), .req_ba(r_ba[2]),
      .req_ra(r_ra[2]), .req_ca(r_ca[2]), .req_len(r_len[2]), .req_wr(r_wr[2])
   );

   function automatic item_t got(int i);
      item_t g;
      g = {r_wr[i], r_id[i], r_ba[i], r_ra[i], r_ca[i], r_len[i]};
      return g;
   endfunction

   // Default payloads: aw 0x10 -> a=1, ar 0x20 -> a=2; identical under every map.
   function automatic item_t mk(bit wr);
      item_t e;
      if (wr) e = {1'b1, 4'hA, 2'd0, 16'd0, 10'd1, 8'd1};
      else    e = {1'b0, 4'h5, 2'd0, 16'd0, 10'd2, 8'd3};
      return e;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, req);
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_seq(string s0, string s1, string s2);
      for (int k = 0; k < s0.len(); k++) begin
         exp_q.push_back(mk(s0.getc(k) == "W"));
         exp_q.push_back(mk(s1.getc(k) == "W"));
         exp_q.push_back(mk(s2.getc(k) == "W"));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic set_default_payload();
      aw_id = 4'hA; aw_addr = 32'h10; aw_len = 8'd1;
      ar_id = 4'h5; ar_addr = 32'h20; ar_len = 8'd3;
   endtask

   // Monitor: pops one expected item per instance on every accepted request and checks
   // that a stalled request stays put.
   initial begin
      item_t prev [3];
      item_t e;
      logic  stall_prev;
      stall_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst && req_ready && (vld != 3'b000)) begin
            for (int i = 0; i < 3; i++) begin
               check($sformatf("sb_pending_u%0d", i), 64'(exp_q.size() > 0), 64'd1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  check($sformatf("sb_valid_u%0d", i), 64'(vld[i]), 64'd1);
                  check($sformatf("sb_item_u%0d", i), 64'(got(i)), 64'(e));
               end
            end
         end
         if (stall_prev && !rst) begin
            for (int i = 0; i < 3; i++) begin
               check($sformatf("stall_hold_u%0d", i), 64'(got(i)), 64'(prev[i]));
               check($sformatf("stall_valid_u%0d", i), 64'(vld[i]), 64'd1);
            end
         end
         stall_prev = !rst && vld[0] && !req_ready;
         for (int i = 0; i < 3; i++) prev[i] = got(i);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      int t;
      set_default_payload();
      // Reset with both valids asserted.
      rst = 1'b1; ar_valid = 1'b1; aw_valid = 1'b1; req_ready = 1'b1;
      cyc(2);
      check("rst_valid", 64'(vld), 64'd0);
      check("rst_aw_ready", 64'(aw_rdy), 64'd0);
      check("rst_ar_ready", 64'(ar_rdy), 64'd0);
      for (int i = 0; i < 3; i++) check($sformatf("rst_outputs_u%0d", i), 64'(got(i)), 64'd0);
      rst = 1'b0;
      #1;
      check("first_grant_aw", 64'(aw_rdy), 64'b111);
      check("first_grant_ar", 64'(ar_rdy), 64'b000);
      push_seq("W", "W", "W");
      cyc(1);
      ar_valid = 1'b0; aw_valid = 1'b0;
      check("latency_first", 64'(vld), 64'b111);
      cyc(2);

      // Address maps: aw 0x0012_3450 (a=0x12345), then ar 0x0001_4000 (a=0x1400).
      aw_id = 4'h3; aw_addr = 32'h0012_3450; aw_len = 8'd7;
      exp_q.push_back({1'b1, 4'h3, 2'd0, 16'h12, 10'h345, 8'd7});
      exp_q.push_back({1'b1, 4'h3, 2'd0, 16'h48, 10'h345, 8'd7});
      exp_q.push_back({1'b1, 4'h3, 2'd2, 16'h12, 10'h345, 8'd7});
      aw_valid = 1'b1;
      cyc(1);
      aw_valid = 1'b0;
      check("latency_aw", 64'(vld), 64'b111);
      cyc(1);
      ar_id = 4'h9; ar_addr = 32'h0001_4000; ar_len = 8'd2;
      exp_q.push_back({1'b0, 4'h9, 2'd1, 16'h1, 10'h0, 8'd2});
      exp_q.push_back({1'b0, 4'h9, 2'd0, 16'h5, 10'h0, 8'd2});
      exp_q.push_back({1'b0, 4'h9, 2'd0, 16'h1, 10'h0, 8'd2});
      ar_valid = 1'b1;
      cyc(1);
      ar_valid = 1'b0;
      check("latency_ar", 64'(vld), 64'b111);
      cyc(2);
      set_default_payload();

      // Continuous contention: starvation limit 4, pure write priority, round-robin.
      do_reset();
      push_seq("WWWWRWWWWR", "WWWWWWWWWW", "WRWRWRWRWR");
      ar_valid = 1'b1; aw_valid = 1'b1;
      cyc(10);
      ar_valid = 1'b0; aw_valid = 1'b0;
      cyc(2);

      // Reads alone for three cycles, then both.
      do_reset();
      push_seq("RRRW", "RRRW", "RRRW");
      ar_valid = 1'b1;
      cyc(3);
      aw_valid = 1'b1;
      cyc(1);
      ar_valid = 1'b0; aw_valid = 1'b0;
      cyc(2);

      // Backpressure in the middle of a write streak.
      do_reset();
      push_seq("WWWWR", "WWWWW", "WRWRW");
      ar_valid = 1'b1; aw_valid = 1'b1;
      cyc(2);
      req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         check("stall_aw_ready", 64'(aw_rdy), 64'd0);
         check("stall_ar_ready", 64'(ar_rdy), 64'd0);
      end
      req_ready = 1'b1;
      cyc(1);
      check("no_bubble", 64'(vld), 64'b111);
      cyc(2);
      ar_valid = 1'b0; aw_valid = 1'b0;
      cyc(2);

      // Reset while a request is held under backpressure.
      do_reset();
      req_ready = 1'b0;
      ar_valid = 1'b1; aw_valid = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(1);
      check("midrst_valid", 64'(vld), 64'd0);
      push_seq("WWWWR", "WWWWW", "WRWRW");
      rst = 1'b0; req_ready = 1'b1;
      cyc(5);
      ar_valid = 1'b0; aw_valid = 1'b0;
      cyc(2);

      t = 0;
      while (exp_q.size() != 0 && t < 20) begin
         cyc(1);
         t++;
      end
      check("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
